// File: rtl/tpm_spi_host.sv
// tpm_spi_host: host-side TPM SPI engine that turns one-byte register read/write
// requests into a 32-bit header, optional flow-control wait bytes and one data byte.
module tpm_spi_host #(
   parameter int CLK_DIV  = 2,
   parameter int MAX_WAIT = 64
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        rw,
   input  logic [23:0] addr,
   input  logic [7:0]  wdata,
   output logic [7:0]  rdata,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic        sclk,
   output logic        cs_n,
   output logic        mosi,
   input  logic        miso
);
   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int WW = $clog2(MAX_WAIT + 1);
   localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
   localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_CS_SETUP = 3'd1,
      S_HEADER   = 3'd2,
      S_WAIT     = 3'd3,
      S_DATA     = 3'd4,
      S_CS_HOLD  = 3'd5,
      S_CS_GAP   = 3'd6
   } state_t;

   state_t        state_r, state_nxt;
   logic [CW-1:0] cnt_r, cnt_nxt;
   logic [4:0]    bit_r, bit_nxt;
   logic [WW-1:0] wait_r, wait_nxt;
   logic [39:0]   tx_r, tx_nxt;
   logic [7:0]    rx_r, rx_nxt;
   logic          rw_r, rw_nxt;
   logic          abort_r, abort_nxt;
   logic          sclk_r, sclk_nxt;
   logic          cs_n_r, cs_n_nxt;
   logic          mosi_r, mosi_nxt;
   logic          busy_r, busy_nxt;
   logic          done_r, done_nxt;
   logic          error_r, error_nxt;
   logic [7:0]    rdata_r, rdata_nxt;

   logic tick_s;
   logic fall_s;

   // Every phase (setup, SCLK half-period, hold, gap) lasts CLK_DIV cycles, so one
   // free-running divider marks all phase ends; a tick while SCLK is high is a fall.
   assign tick_s = (cnt_r == CNT_LAST);
   assign fall_s = tick_s & sclk_r;

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_nxt;
      end
   end

   // Next-state decode
   always_comb begin
      state_nxt = state_r;
      case (state_r)
         S_IDLE: begin
            if (start) state_nxt = S_CS_SETUP;
            else       state_nxt = S_IDLE;
         end
         S_CS_SETUP: begin
            if (tick_s) state_nxt = S_HEADER;
            else        state_nxt = S_CS_SETUP;
         end
         S_HEADER: begin
            if (fall_s && (bit_r == 5'd31)) state_nxt = miso ? S_DATA : S_WAIT;
            else                            state_nxt = S_HEADER;
         end
         S_WAIT: begin
            if (fall_s && (bit_r == 5'd7)) begin
               if (miso)                      state_nxt = S_DATA;
               else if (wait_r == WAIT_LAST)  state_nxt = S_CS_HOLD;
               else                           state_nxt = S_WAIT;
            end else begin
               state_nxt = S_WAIT;
            end
         end
         S_DATA: begin
            if (fall_s && (bit_r == 5'd7)) state_nxt = S_CS_HOLD;
            else                           state_nxt = S_DATA;
         end
         S_CS_HOLD: begin
            if (tick_s) state_nxt = S_CS_GAP;
            else        state_nxt = S_CS_HOLD;
         end
         S_CS_GAP: begin
            if (tick_s) state_nxt = S_IDLE;
            else        state_nxt = S_CS_GAP;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Output and datapath next values; the final SCLK low phase doubles as CS hold time
   always_comb begin
      cnt_nxt   = cnt_r;
      bit_nxt   = bit_r;
      wait_nxt  = wait_r;
      tx_nxt    = tx_r;
      rx_nxt    = rx_r;
      rw_nxt    = rw_r;
      abort_nxt = abort_r;
      sclk_nxt  = sclk_r;
      cs_n_nxt  = cs_n_r;
      mosi_nxt  = mosi_r;
      busy_nxt  = busy_r;
      done_nxt  = 1'b0;
      error_nxt = 1'b0;
      rdata_nxt = rdata_r;
      if (state_r != S_IDLE) begin
         cnt_nxt = tick_s ? {CW{1'b0}} : cnt_r + CW'(1);
      end else begin
         cnt_nxt = {CW{1'b0}};
      end
      case (state_r)
         S_IDLE: begin
            if (start) begin
               busy_nxt  = 1'b1;
               cs_n_nxt  = 1'b0;
               rw_nxt    = rw;
               abort_nxt = 1'b0;
               wait_nxt  = {WW{1'b0}};
               bit_nxt   = 5'd0;
               mosi_nxt  = rw;
               tx_nxt    = {1'b0, 6'd0, addr, (rw ? 8'h00 : wdata), 1'b0};
            end else begin
               busy_nxt  = 1'b0;
            end
         end
         S_CS_SETUP: begin
            if (tick_s) sclk_nxt = 1'b1;
            else        sclk_nxt = 1'b0;
         end
         S_HEADER: begin
            sclk_nxt = tick_s ? ~sclk_r : sclk_r;
            if (fall_s) begin
               if (bit_r == 5'd31) begin
                  bit_nxt = 5'd0;
                  if (miso) {mosi_nxt, tx_nxt} = {tx_r, 1'b0};
                  else      mosi_nxt = 1'b0;
               end else begin
                  bit_nxt = bit_r + 5'd1;
                  {mosi_nxt, tx_nxt} = {tx_r, 1'b0};
               end
            end else begin
               bit_nxt = bit_r;
            end
         end
         S_WAIT: begin
            sclk_nxt = tick_s ? ~sclk_r : sclk_r;
            if (fall_s) begin
               mosi_nxt = 1'b0;
               if (bit_r == 5'd7) begin
                  bit_nxt  = 5'd0;
                  wait_nxt = wait_r + WW'(1);
                  if (miso)                     {mosi_nxt, tx_nxt} = {tx_r, 1'b0};
                  else if (wait_r == WAIT_LAST) abort_nxt = 1'b1;
                  else                          abort_nxt = 1'b0;
               end else begin
                  bit_nxt = bit_r + 5'd1;
               end
            end else begin
               bit_nxt = bit_r;
            end
         end
         S_DATA: begin
            sclk_nxt = tick_s ? ~sclk_r : sclk_r;
            if (fall_s) begin
               rx_nxt = {rx_r[6:0], miso};
               {mosi_nxt, tx_nxt} = {tx_r, 1'b0};
               if (bit_r == 5'd7) bit_nxt = 5'd0;
               else               bit_nxt = bit_r + 5'd1;
            end else begin
               bit_nxt = bit_r;
            end
         end
         S_CS_HOLD: begin
            sclk_nxt = 1'b0;
            if (tick_s) begin
               cs_n_nxt  = 1'b1;
               done_nxt  = 1'b1;
               error_nxt = abort_r;
               if (rw_r && !abort_r) rdata_nxt = rx_r;
               else                  rdata_nxt = rdata_r;
            end else begin
               cs_n_nxt  = 1'b0;
            end
         end
         S_CS_GAP: begin
            if (tick_s) busy_nxt = 1'b0;
            else        busy_nxt = 1'b1;
         end
         default: begin
            sclk_nxt = 1'b0;
            cs_n_nxt = 1'b1;
            mosi_nxt = 1'b0;
            busy_nxt = 1'b0;
         end
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_r   <= {CW{1'b0}};
         bit_r   <= 5'd0;
         wait_r  <= {WW{1'b0}};
         tx_r    <= 40'd0;
         rx_r    <= 8'h00;
         rw_r    <= 1'b0;
         abort_r <= 1'b0;
         sclk_r  <= 1'b0;
         cs_n_r  <= 1'b1;
         mosi_r  <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         error_r <= 1'b0;
         rdata_r <= 8'h00;
      end else begin
         cnt_r   <= cnt_nxt;
         bit_r   <= bit_nxt;
         wait_r  <= wait_nxt;
         tx_r    <= tx_nxt;
         rx_r    <= rx_nxt;
         rw_r    <= rw_nxt;
         abort_r <= abort_nxt;
         sclk_r  <= sclk_nxt;
         cs_n_r  <= cs_n_nxt;
         mosi_r  <= mosi_nxt;
         busy_r  <= busy_nxt;
         done_r  <= done_nxt;
         error_r <= error_nxt;
         rdata_r <= rdata_nxt;
      end
   end

   assign rdata = rdata_r;
   assign busy  = busy_r;
   assign done  = done_r;
   assign error = error_r;
   assign sclk  = sclk_r;
   assign cs_n  = cs_n_r;
   assign mosi  = mosi_r;
endmodule

// File: doc/tpm_spi_host.md
# tpm_spi_host

Host-side (initiator) TPM SPI controller: turns single-byte register read/write requests from a local bus into TPM SPI transactions (32-bit header, flow-control wait states, 1 data byte) on SCLK/CS#/MOSI/MISO. It is the counterpart of the `tpm` SPI device block. It drives that block's `clk`/`cs_n`/`mosi` inputs and samples its `miso`. It replaces behavioural host stimulus in system-level benches and serves as the host engine on FPGA test targets.

## Interface
- `CLK_DIV`, default 2: SCLK half-period in `clk` cycles (D). Allowed range is ≥1.
- `MAX_WAIT`, default 64: maximum number of wait bytes before the transaction is aborted. Allowed range is ≥1.
- `clk`  in  1  system clock. The block uses one clock domain, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request strobe. It is accepted only while `busy`=0.
- `rw`  in  1  1 = read, 0 = write. Captured at accept.
- `addr`  in  24  TPM register address. Captured at accept.
- `wdata`  in  8  write byte. Captured at accept.
- `rdata`  out  8  read byte. Valid from the `done` pulse until the next read completes.
- `busy`  out  1  high from the cycle after accept until the end of the CS gap.
- `done`  out  1  one-cycle pulse at the end of every transaction.
- `error`  out  1  one-cycle pulse coincident with `done` when a wait timeout occurs.
- `sclk`  out  1  SPI clock, mode 0, idles low.
- `cs_n`  out  1  chip select, active low.
- `mosi`  out  1  host→device data, MSB first.
- `miso`  in  1  device→host data and flow control.

## Operation
- Header = {`rw`, 1'b0, 6'd0 (size−1, always 1 byte), `addr[23:0]`}. It is shifted MSB first.
- FSM states: IDLE → CS_SETUP → HEADER → (WAIT)* → DATA → CS_HOLD → CS_GAP → IDLE.
- IDLE, `start`=1: capture `rw`/`addr`/`wdata`, set `busy`, go to CS_SETUP. `start` is ignored while `busy`=1.
- HEADER: 32 SCLK periods. MISO is ignored except at the 32nd sample.
  - 32nd sample = 1: go to DATA.
  - 32nd sample = 0: go to WAIT.
- WAIT: groups of 8 SCLK periods, with `mosi`=0. MISO is sampled on the 8th period of each group.
  - Sample = 1: go to DATA.
  - Sample = 0 and wait count < `MAX_WAIT`: start another group.
  - Sample = 0 and wait count = `MAX_WAIT`: set the abort flag and go to CS_HOLD without a DATA phase.
- DATA: 8 SCLK periods.
  - Write: `mosi` carries `wdata` MSB first.
  - Read: MISO is shifted in MSB first; `rdata` updates only at `done`.
  - `mosi`=0 during reads.
- CS_HOLD: wait D cycles, then raise `cs_n` and pulse `done`. Pulse `error` too if aborted. On abort, `rdata` is unchanged.
- CS_GAP: `cs_n` stays high for D cycles, then `busy`=0.
- Wait counter width is ceil(log2(MAX_WAIT+1)). It is cleared at each accept.

## Timing
- Reset values: `cs_n`=1, `sclk`=0, `mosi`=0, `busy`=0, `done`=0, `error`=0, `rdata`=8'h00, FSM=IDLE.
- Reset is asynchronous mid-transaction: outputs return to reset values immediately and no `done` pulse is produced.
- Accept at clock edge T0: `cs_n`=0 and `busy`=1 from T0+1.
- The first SCLK rise is D cycles after `cs_n` falls.
- Each SCLK period is D cycles high, then D cycles low.
- `mosi` changes only in the cycle `sclk` falls, or at `cs_n` fall for bit 31.
- `mosi` is stable for the whole high phase.
- MISO is sampled in the last `clk` cycle of each high phase.
- `cs_n` rises D cycles after the final SCLK falling edge. N = 40 + 8·W total SCLK periods, where W = wait bytes.
- `cs_n` low duration = D + 2D·N cycles. Example: D=2, W=0 gives 162 cycles.
- `done` is high in the same cycle `cs_n` returns to 1.
- `busy` falls D cycles later. The earliest next accept is the cycle `busy`=0.
- `sclk` is low whenever `cs_n`=1. There is no partial SCLK pulse at abort or at CS transitions.

## Test plan
- Write 8'h02 to 24'h000000 against `tpm` + `regs_module`, no wait:
  - header on MOSI = 32'h00000000, then 8'h02.
  - `done` after 162 cycles (D=2).
  - `activeLocality` = 0.
- Write 8'h83 to 24'h000008 with the device model inserting 2 wait bytes:
  - SCLK count = 56.
  - `mosi`=0 during WAIT.
  - device receives 8'h83.
  - `error`=0.
- Read 24'h000014 with model returning 8'hA5 after 1 wait byte:
  - header 32'h80000014.
  - `rdata`=8'hA5 at `done`.
  - SCLK count = 48.
- `MAX_WAIT`=2, MISO held 0:
  - exactly 2 wait bytes (48 SCLKs).
  - `done` and `error` pulse together.
  - `rdata` unchanged.
  - `cs_n` high afterwards.
- `start` pulsed while `busy`:
  - ignored.
  - exactly one transaction on the bus.
  - back-to-back accept only once `busy`=0, with `cs_n` high for ≥D cycles between transactions.
- `reset_n` low during header bit 10:
  - `cs_n`=1 and `sclk`=0 immediately.
  - no `done`.
  - next `start` produces a complete, correct transaction.
